ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues one word request at a time to instruction memory over a valid/ready request channel, taking a valid-only response.
- Presents the fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump/trap) and discards any in-flight stale response.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, value driven on ifu_inst_o while no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
imem_req_valid_o  output  1  fetch request valid
imem_req_ready_i  input  1  memory accepts request
imem_req_addr_o  output  32  word address of request; bits[1:0] always 0
imem_resp_valid_i  input  1  response data valid, single cycle, no backpressure
imem_resp_data_i  input  32  fetched instruction word
redirect_valid_i  input  1  redirect PC this cycle
redirect_pc_i  input  32  redirect target
ifu_inst_valid_o  output  1  instruction to decode valid
ifu_inst_ready_i  input  1  decode accepts instruction
ifu_inst_o  output  32  instruction, feeds decode_inst_i
ifu_pc_o  output  32  PC of ifu_inst_o

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=REQ, kill=0, imem_req_valid_o=0 during the reset cycle, ifu_inst_valid_o=0, ifu_inst_o=NOP_INST, ifu_pc_o=RESET_PC.
- First request: asserted in the first cycle after rst deasserts.
- Outstanding requests: at most one.
- State REQ:
  - imem_req_valid_o=1, imem_req_addr_o={pc[31:2],2'b00}.
  - req_valid && req_ready → WAIT.
  - Address is held stable while stalled, except on redirect.
- State WAIT:
  - imem_req_valid_o=0.
  - On resp_valid with kill=0: latch data into ifu_inst_o and pc into ifu_pc_o, set ifu_inst_valid_o=1 next cycle, → HOLD.
  - On resp_valid with kill=1: drop the data, clear kill, → REQ.
- State HOLD:
  - ifu_inst_valid_o=1; ifu_inst_o and ifu_pc_o are stable until handshake.
  - On valid && ready: pc<=pc+4, ifu_inst_valid_o=0 next cycle, ifu_inst_o=NOP_INST, → REQ.
- Redirect (highest priority, any state):
  - pc<=redirect_pc_i & ~32'h3 (low bits forced to 0).
  - REQ: stay in REQ; new address is driven the next cycle. If req_ready coincides in the same cycle, the accepted request is stale: set kill=1, → WAIT.
  - WAIT: set kill=1. If resp_valid arrives in the same cycle, drop it, kill stays 0, → REQ.
  - HOLD: ifu_inst_valid_o=0 next cycle, → REQ. If the handshake coincides, the instruction counts as consumed and the PC is the redirect target, not pc+4.
- Latency:
  - Request accepted at cycle N, response at N+k → ifu_inst_valid_o at N+k+1.
  - With k=1 and decode always ready, one instruction per 3 cycles.
- PC arithmetic: 32-bit, pc+4 wraps, so 32'hFFFF_FFFC → 32'h0000_0000.
- Response arriving in REQ or HOLD (protocol violation): ignored.
- rst asserted mid-operation: everything returns to reset values the next cycle; a later stray response is ignored because state is REQ.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt_o (32) and perf_stall_cnt_o (32), both reset to 0:
  - perf_fetch_cnt_o increments on each decode handshake.
  - perf_stall_cnt_o increments each cycle with ifu_inst_valid_o=1 && ifu_inst_ready_i=0.
  - Both wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then mem k=1, decode always ready, memory returns 0x00100093, 0x00200113, 0x00300193 → addrs 0x80000000, 0x80000004, 0x80000008; ifu_inst_o/ifu_pc_o pairs match; valid at cycles 3, 6, 9 after rst release.
- imem_req_ready_i low 4 cycles → req_valid held 1, addr 0x80000000 constant; request accepted on the 5th cycle.
- Decode ready low 5 cycles in HOLD → inst/pc stable, no new request issued; with IFU_PERF_CNT_EN, stall count=5 and fetch count=1 after the handshake.
- Redirect to 0x80000102 while in WAIT, response 0xDEADBEEF arrives 2 cycles later → response dropped, never valid to decode; next request addr=0x80000100.
- Redirect coinciding with a decode handshake in HOLD, target 0x80001000 → next request addr=0x80001000, not pc+4; redirect coinciding with req_ready → the old response is killed.
- Redirect to 0xFFFFFFFC, then handshake → next addr 0x00000000; rst asserted in WAIT → next cycle req_valid=1 at 0x80000000 and a late response is ignored.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word request to imem, hands the instruction and its PC to decode.
// Define IFU_PERF_CNT_EN to add the decode-handshake and decode-stall performance counters.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        ifu_inst_valid_o,
   input  logic        ifu_inst_ready_i,
   output logic [31:0] ifu_inst_o,
   output logic [31:0] ifu_pc_o
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt_o,
   output logic [31:0] perf_stall_cnt_o
`endif
);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;

   logic        req_fire;
   logic        inst_fire;
   logic [31:0] redirect_target;

   // The request is suppressed combinationally while rst is high so nothing leaks out during reset.
   assign imem_req_valid_o = (state_q == ST_REQ) && !rst;
   assign imem_req_addr_o  = {pc_q[31:2], 2'b00};
   assign ifu_inst_valid_o = (state_q == ST_HOLD);
   assign ifu_inst_o       = inst_q;
   assign ifu_pc_o         = inst_pc_q;

   assign req_fire        = imem_req_valid_o && imem_req_ready_i;
   assign inst_fire       = ifu_inst_valid_o && ifu_inst_ready_i;
   assign redirect_target = redirect_pc_i & ~32'h3;

   always_comb begin
      // NOTE: every next-state value gets a default first so this block can never infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      kill_d    = kill_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;

      case (state_q)
         ST_REQ: begin
            if (redirect_valid_i) begin
               pc_d = redirect_target;
               // A request accepted alongside a redirect fetches the old path; its response must die.
               if (req_fire) begin
                  kill_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end else if (req_fire) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirect_valid_i) begin
               pc_d = redirect_target;
               if (imem_resp_valid_i) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  kill_d  = 1'b1;
               end
            end else if (imem_resp_valid_i) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  inst_d    = imem_resp_data_i;
                  inst_pc_d = pc_q;
                  state_d   = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            // A redirect wins over pc+4 even when decode takes the instruction in the same cycle.
            if (redirect_valid_i) begin
               pc_d    = redirect_target;
               inst_d  = NOP_INST;
               state_d = ST_REQ;
            end else if (inst_fire) begin
               pc_d    = pc_q + 32'd4;
               inst_d  = NOP_INST;
               state_d = ST_REQ;
            end
         end

         default: begin
            kill_d  = 1'b0;
            inst_d  = NOP_INST;
            state_d = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_REQ;
         pc_q      <= RESET_PC;
         kill_q    <= 1'b0;
         inst_q    <= NOP_INST;
         inst_pc_q <= RESET_PC;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         pc_q      <= pc_d;
         kill_q    <= kill_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt_o <= 32'd0;
         perf_stall_cnt_o <= 32'd0;
      end else begin
         if (inst_fire) begin
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
         end
         if (ifu_inst_valid_o && !ifu_inst_ready_i) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized run against a program-order model.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i;
   logic [31:0] imem_resp_data_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        ifu_inst_valid_o;
   logic        ifu_inst_ready_i;
   logic [31:0] ifu_inst_o;
   logic [31:0] ifu_pc_o;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt_o;
   logic [31:0] perf_stall_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req_valid_o  (imem_req_valid_o),
      .imem_req_ready_i  (imem_req_ready_i),
      .imem_req_addr_o   (imem_req_addr_o),
      .imem_resp_valid_i (imem_resp_valid_i),
      .imem_resp_data_i  (imem_resp_data_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_pc_i     (redirect_pc_i),
      .ifu_inst_valid_o  (ifu_inst_valid_o),
      .ifu_inst_ready_i  (ifu_inst_ready_i),
      .ifu_inst_o        (ifu_inst_o),
      .ifu_pc_o          (ifu_pc_o)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt_o  (perf_fetch_cnt_o),
      .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
   );

   // Contents of the modelled instruction memory at any word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      imem_req_ready_i  = 1'b0;
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = 32'h0;
      redirect_valid_i  = 1'b0;
      redirect_pc_i     = 32'h0;
      ifu_inst_ready_i  = 1'b0;
   endtask

   // Leaves the bench at a falling edge with rst just released: the caller drives cycle 1.
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      #1;
      checks++;
      if ({imem_req_valid_o, ifu_inst_valid_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valids got req=%b inst=%b exp 0 0", imem_req_valid_o, ifu_inst_valid_o);
      end
      checks++;
      if (ifu_inst_o !== NOP) begin
         errors++;
         $display("FAIL reset_inst got %h exp %h", ifu_inst_o, NOP);
      end
      checks++;
      if (ifu_pc_o !== RESET_PC) begin
         errors++;
         $display("FAIL reset_pc got %h exp %h", ifu_pc_o, RESET_PC);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if ({perf_fetch_cnt_o, perf_stall_cnt_o} !== 64'h0) begin
         errors++;
         $display("FAIL reset_perf got %h/%h exp 0/0", perf_fetch_cnt_o, perf_stall_cnt_o);
      end
`endif
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RESET_PC) begin
         errors++;
         $display("FAIL first_req got v=%b a=%h exp 1 %h", imem_req_valid_o, imem_req_addr_o, RESET_PC);
      end
   endtask

   task automatic test_basic();
      logic [31:0] prog [3];
      int nreq = 0;
      int nout = 0;
      logic resp_due = 1'b0;
      prog[0] = 32'h0010_0093;
      prog[1] = 32'h0020_0113;
      prog[2] = 32'h0030_0193;
      do_reset();
      imem_req_ready_i = 1'b1;
      ifu_inst_ready_i = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         imem_resp_valid_i = resp_due;
         imem_resp_data_i  = resp_due ? prog[(nreq - 1) % 3] : 32'h0;
         #1;
         resp_due = 1'b0;
         if (imem_req_valid_o) begin
            checks++;
            if (imem_req_addr_o !== RESET_PC + 32'(4 * nreq)) begin
               errors++;
               $display("FAIL basic_addr c=%0d got %h exp %h", c, imem_req_addr_o, RESET_PC + 32'(4 * nreq));
            end
            resp_due = 1'b1;
            nreq++;
         end
         if (ifu_inst_valid_o) begin
            checks++;
            if (c != 3 * (nout + 1) || ifu_inst_o !== prog[nout % 3] || ifu_pc_o !== RESET_PC + 32'(4 * nout)) begin
               errors++;
               $display("FAIL basic_out c=%0d got %h@%h exp %h@%h at cycle %0d", c, ifu_inst_o, ifu_pc_o,
                        prog[nout % 3], RESET_PC + 32'(4 * nout), 3 * (nout + 1));
            end
            nout++;
         end
         tick();
      end
      checks++;
      if (nout != 3 || nreq != 3) begin
         errors++;
         $display("FAIL basic_count got req=%0d out=%0d exp 3 3", nreq, nout);
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      ifu_inst_ready_i = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         imem_req_ready_i = (c == 5);
         #1;
         checks++;
         if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RESET_PC) begin
            errors++;
            $display("FAIL stall_req c=%0d got v=%b a=%h exp 1 %h", c, imem_req_valid_o, imem_req_addr_o, RESET_PC);
         end
         tick();
      end
      imem_req_ready_i  = 1'b0;
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = 32'hA5A5_0013;
      #1;
      checks++;
      if (imem_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_accept got req_valid=%b exp 0", imem_req_valid_o);
      end
      tick();
      imem_resp_valid_i = 1'b0;
      #1;
      checks++;
      if (ifu_inst_valid_o !== 1'b1 || ifu_inst_o !== 32'hA5A5_0013) begin
         errors++;
         $display("FAIL stall_resp got v=%b i=%h exp 1 a5a50013", ifu_inst_valid_o, ifu_inst_o);
      end
   endtask

   task automatic test_decode_stall();
      do_reset();
      imem_req_ready_i = 1'b1;
      tick();
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = 32'h0010_0093;
      tick();
      imem_resp_valid_i = 1'b0;
      for (int c = 3; c <= 7; c++) begin
         #1;
         checks++;
         if ({ifu_inst_valid_o, imem_req_valid_o} !== 2'b10 || ifu_inst_o !== 32'h0010_0093 || ifu_pc_o !== RESET_PC) begin
            errors++;
            $display("FAIL hold_stable c=%0d got v=%b req=%b i=%h pc=%h exp 1 0 00100093 %h",
                     c, ifu_inst_valid_o, imem_req_valid_o, ifu_inst_o, ifu_pc_o, RESET_PC);
         end
         tick();
      end
      ifu_inst_ready_i = 1'b1;
      #1;
      checks++;
      if (ifu_inst_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL hold_handshake got valid=%b exp 1", ifu_inst_valid_o);
      end
      tick();
      imem_req_ready_i = 1'b0;
      #1;
      checks++;
      if ({ifu_inst_valid_o, imem_req_valid_o} !== 2'b01 || ifu_inst_o !== NOP || imem_req_addr_o !== RESET_PC + 32'd4) begin
         errors++;
         $display("FAIL hold_after got v=%b req=%b i=%h a=%h exp 0 1 %h %h",
                  ifu_inst_valid_o, imem_req_valid_o, ifu_inst_o, imem_req_addr_o, NOP, RESET_PC + 32'd4);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_fetch_cnt_o !== 32'd1 || perf_stall_cnt_o !== 32'd5) begin
         errors++;
         $display("FAIL hold_perf got fetch=%0d stall=%0d exp 1 5", perf_fetch_cnt_o, perf_stall_cnt_o);
      end
`endif
   endtask

   task automatic test_redirect_wait();
      logic seen = 1'b0;
      do_reset();
      imem_req_ready_i = 1'b1;
      ifu_inst_ready_i = 1'b1;
      tick();
      for (int c = 2; c <= 6; c++) begin
         redirect_valid_i  = (c == 2);
         redirect_pc_i     = 32'h8000_0102;
         imem_resp_valid_i = (c == 4) || (c == 6);
         imem_resp_data_i  = (c == 4) ? 32'hDEAD_BEEF : 32'h1111_1111;
         #1;
         if (ifu_inst_valid_o) seen = 1'b1;
         if (c == 5) begin
            checks++;
            if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin
               errors++;
               $display("FAIL rw_addr got v=%b a=%h exp 1 80000100", imem_req_valid_o, imem_req_addr_o);
            end
         end
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rw_stale_valid got early valid=%b exp 0", seen);
      end
      checks++;
      if (ifu_inst_valid_o !== 1'b1 || ifu_inst_o !== 32'h1111_1111 || ifu_pc_o !== 32'h8000_0100) begin
         errors++;
         $display("FAIL rw_out got v=%b i=%h pc=%h exp 1 11111111 80000100", ifu_inst_valid_o, ifu_inst_o, ifu_pc_o);
      end
   endtask

   task automatic test_redirect_handshake();
      do_reset();
      imem_req_ready_i = 1'b1;
      ifu_inst_ready_i = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         redirect_valid_i  = (c == 3) || (c == 4);
         redirect_pc_i     = (c == 3) ? 32'h8000_1000 : 32'h8000_2000;
         imem_resp_valid_i = (c == 2) || (c == 5) || (c == 7);
         imem_resp_data_i  = (c == 2) ? 32'h0010_0093 : (c == 5) ? 32'hBADB_AD00 : 32'h0050_0293;
         #1;
         if (c == 3) begin
            checks++;
            if (ifu_inst_valid_o !== 1'b1 || ifu_pc_o !== RESET_PC) begin
               errors++;
               $display("FAIL rh_hold got v=%b pc=%h exp 1 %h", ifu_inst_valid_o, ifu_pc_o, RESET_PC);
            end
         end
         if (c == 4) begin
            checks++;
            if ({imem_req_valid_o, ifu_inst_valid_o} !== 2'b10 || imem_req_addr_o !== 32'h8000_1000 || ifu_inst_o !== NOP) begin
               errors++;
               $display("FAIL rh_target got req=%b v=%b a=%h i=%h exp 1 0 80001000 %h",
                        imem_req_valid_o, ifu_inst_valid_o, imem_req_addr_o, ifu_inst_o, NOP);
            end
         end
         if (c == 5) begin
            checks++;
            if (imem_req_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL rh_kill_wait got req_valid=%b exp 0", imem_req_valid_o);
            end
         end
         if (c == 6) begin
            checks++;
            if ({imem_req_valid_o, ifu_inst_valid_o} !== 2'b10 || imem_req_addr_o !== 32'h8000_2000) begin
               errors++;
               $display("FAIL rh_killed got req=%b v=%b a=%h exp 1 0 80002000", imem_req_valid_o, ifu_inst_valid_o, imem_req_addr_o);
            end
         end
         if (c == 8) begin
            checks++;
            if (ifu_inst_valid_o !== 1'b1 || ifu_inst_o !== 32'h0050_0293 || ifu_pc_o !== 32'h8000_2000) begin
               errors++;
               $display("FAIL rh_out got v=%b i=%h pc=%h exp 1 00500293 80002000", ifu_inst_valid_o, ifu_inst_o, ifu_pc_o);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      ifu_inst_ready_i = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         rst               = (c == 6);
         redirect_valid_i  = (c == 1);
         redirect_pc_i     = 32'hFFFF_FFFE;
         imem_req_ready_i  = !(c == 1 || c == 7 || c == 8);
         imem_resp_valid_i = (c == 3) || (c == 7);
         imem_resp_data_i  = (c == 3) ? 32'h1234_5678 : 32'hDEAD_BEEF;
         #1;
         if (c == 2 || c == 5 || c == 7 || c == 8) begin
            logic [31:0] exp_a;
            exp_a = (c == 2) ? 32'hFFFF_FFFC : (c == 5) ? 32'h0000_0000 : RESET_PC;
            checks++;
            if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== exp_a || ifu_inst_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL wr_req c=%0d got req=%b a=%h v=%b exp 1 %h 0", c, imem_req_valid_o, imem_req_addr_o, ifu_inst_valid_o, exp_a);
            end
         end
         if (c == 4) begin
            checks++;
            if (ifu_inst_valid_o !== 1'b1 || ifu_pc_o !== 32'hFFFF_FFFC || ifu_inst_o !== 32'h1234_5678) begin
               errors++;
               $display("FAIL wr_hold got v=%b pc=%h i=%h exp 1 fffffffc 12345678", ifu_inst_valid_o, ifu_pc_o, ifu_inst_o);
            end
         end
         if (c == 6) begin
            checks++;
            if ({imem_req_valid_o, ifu_inst_valid_o} !== 2'b00) begin
               errors++;
               $display("FAIL wr_in_reset got req=%b v=%b exp 0 0", imem_req_valid_o, ifu_inst_valid_o);
            end
         end
         if (c == 8) begin
            checks++;
            if (ifu_inst_o !== NOP) begin
               errors++;
               $display("FAIL wr_stray got inst=%h exp %h", ifu_inst_o, NOP);
            end
         end
         tick();
      end
      rst = 1'b0;
   endtask

   // Program-order model: exp_pc is the next instruction decode must see; a memory answers each accepted request.
   task automatic test_random();
      logic [31:0] exp_pc, pend_addr, prev_inst, prev_pc, tgt;
      logic        pend, prev_hold_stall, prev_req_stall, busy, hs, redir;
      int          dly, n_hs, n_stall;
      do_reset();
      exp_pc = RESET_PC;
      pend = 1'b0; dly = 0; pend_addr = 32'h0;
      prev_hold_stall = 1'b0; prev_req_stall = 1'b0; prev_inst = 32'h0; prev_pc = 32'h0;
      n_hs = 0; n_stall = 0;
      for (int c = 0; c < 3000; c++) begin
         imem_req_ready_i  = ($urandom_range(0, 3) != 0);
         ifu_inst_ready_i  = ($urandom_range(0, 3) != 0);
         redir             = ($urandom_range(0, 19) == 0);
         tgt               = $urandom;
         redirect_valid_i  = redir;
         redirect_pc_i     = tgt;
         imem_resp_valid_i = 1'b0;
         imem_resp_data_i  = $urandom;
         if (pend) begin
            if (dly == 0) begin
               imem_resp_valid_i = 1'b1;
               imem_resp_data_i  = mem_word(pend_addr);
               pend = 1'b0;
            end else begin
               dly--;
            end
         end
         busy = pend || imem_resp_valid_i;
         #1;
         if (!ifu_inst_valid_o) begin
            checks++;
            if (ifu_inst_o !== NOP) begin
               errors++;
               $display("FAIL rnd_idle_nop c=%0d got %h exp %h", c, ifu_inst_o, NOP);
            end
         end
         if (prev_hold_stall) begin
            checks++;
            if (ifu_inst_valid_o !== 1'b1 || ifu_inst_o !== prev_inst || ifu_pc_o !== prev_pc) begin
               errors++;
               $display("FAIL rnd_hold c=%0d got %b %h@%h exp 1 %h@%h", c, ifu_inst_valid_o, ifu_inst_o, ifu_pc_o, prev_inst, prev_pc);
            end
         end
         if (prev_req_stall) begin
            checks++;
            if (imem_req_valid_o !== 1'b1) begin
               errors++;
               $display("FAIL rnd_req_drop c=%0d got req_valid=%b exp 1", c, imem_req_valid_o);
            end
         end
         if (imem_req_valid_o) begin
            checks++;
            if (imem_req_addr_o !== exp_pc || busy) begin
               errors++;
               $display("FAIL rnd_req c=%0d got a=%h outstanding=%b exp %h 0", c, imem_req_addr_o, busy, exp_pc);
            end
         end
         if (ifu_inst_valid_o) begin
            checks++;
            if (ifu_pc_o !== exp_pc || ifu_inst_o !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL rnd_out c=%0d got %h@%h exp %h@%h", c, ifu_inst_o, ifu_pc_o, mem_word(exp_pc), exp_pc);
            end
         end
         hs = ifu_inst_valid_o && ifu_inst_ready_i;
         if (hs) n_hs++;
         if (ifu_inst_valid_o && !ifu_inst_ready_i) n_stall++;
         if (imem_req_valid_o && imem_req_ready_i) begin
            pend      = 1'b1;
            dly       = $urandom_range(0, 2);
            pend_addr = imem_req_addr_o;
         end
         prev_hold_stall = ifu_inst_valid_o && !ifu_inst_ready_i && !redir;
         prev_req_stall  = imem_req_valid_o && !imem_req_ready_i && !redir;
         prev_inst       = ifu_inst_o;
         prev_pc         = ifu_pc_o;
         exp_pc = redir ? (tgt & ~32'h3) : hs ? exp_pc + 32'd4 : exp_pc;
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (n_hs < 100) begin
         errors++;
         $display("FAIL rnd_progress got %0d handshakes exp at least 100", n_hs);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_fetch_cnt_o !== 32'(n_hs) || perf_stall_cnt_o !== 32'(n_stall)) begin
         errors++;
         $display("FAIL rnd_perf got fetch=%0d stall=%0d exp %0d %0d", perf_fetch_cnt_o, perf_stall_cnt_o, n_hs, n_stall);
      end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_req_stall();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_handshake();
      test_wrap_and_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
